// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Byte stream plus instruction-memory write bus of the program loader.
//   s_valid/s_ready/s_data/s_last : valid/ready byte stream (s_last marks final byte)
//   mem_we/mem_addr/mem_wdata     : one-cycle word write strobe, word address, data
//   modport master : byte source / memory side
//   modport slave  : the loader itself
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Byte-stream program loader for the core's instruction memory. Holds the
//   core in reset, packs incoming bytes little-endian into 32-bit words,
//   writes them to consecutive word addresses from BASE_ADDR, then releases
//   the core RELEASE_DLY cycles after the last byte.
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   bus         : imem_loader_if.slave (byte stream in, imem write bus out)
//   reload      : one-cycle pulse, restarts loading from RUN or ERR
//   core_rst_n  : core reset, active-low, 0 while loading
//   done        : 1 while the core runs
//   err         : 1 after overflow until reload/rst
//   word_count  : words written in the current load
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter int RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  imem_loader_if.slave      bus,
  input  logic              reload,
  output logic              core_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CW    = $clog2(RELEASE_DLY) + 1;

  typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, ERR} state_t;

  state_t          state;
  logic [1:0]      lane;
  logic [23:0]     wbuf;
  logic [CW-1:0]   hold_cnt;
  logic            accept;
  logic            overflow;
  logic [31:0]     word;

  // Word as it would look with the current byte placed in its lane; lanes
  // above the current one are forced to zero, so a short final word is padded
  // and stale bytes in wbuf never leak into a write.
  always_comb begin
    accept   = bus.s_valid && bus.s_ready;
    overflow = (word_count == (ADDR_W+1)'(DEPTH));
    word     = '0;
    case (lane)
      2'd0:    word = {24'h000000, bus.s_data};
      2'd1:    word = {16'h0000, bus.s_data, wbuf[7:0]};
      2'd2:    word = {8'h00, bus.s_data, wbuf[15:0]};
      default: word = {bus.s_data, wbuf[23:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.s_ready   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= ADDR_W'(BASE_ADDR);
      bus.mem_wdata <= '0;
      core_rst_n    <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      word_count    <= '0;
      lane          <= '0;
      wbuf          <= '0;
      hold_cnt      <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          bus.s_ready <= 1'b1;
          if (accept) begin
            if (overflow) begin
              state       <= ERR;
              err         <= 1'b1;
              bus.s_ready <= 1'b0;
            end else begin
              wbuf <= word[23:0];
              lane <= lane + 2'd1;
              if (lane == 2'd3 || bus.s_last) begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= word;
                bus.mem_addr  <= ADDR_W'(BASE_ADDR) + word_count[ADDR_W-1:0];
                word_count    <= word_count + (ADDR_W+1)'(1);
                lane          <= '0;
              end
              if (bus.s_last) begin
                state       <= HOLD;
                bus.s_ready <= 1'b0;
                // HOLD is entered one cycle after the handshake and RUN
                // outputs appear one cycle after leaving HOLD.
                hold_cnt    <= CW'(RELEASE_DLY - 2);
              end else begin
                state <= LOAD;
              end
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state      <= RUN;
            core_rst_n <= 1'b1;
            done       <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN, ERR: begin
          if (reload) begin
            state       <= IDLE;
            bus.s_ready <= 1'b1;
            core_rst_n  <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_count  <= '0;
            lane        <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
